serial_word_deserializer: RTL and testbench

- Receive-side counterpart to the team's parallel-load/serial-shift register.
- Collects a framed serial bit stream, one bit per strobe, into an N-bit word.
- Presents the word on a valid/ready parallel interface.
- Flags framing restarts and overruns.
- Sits between a serial link front end and word-oriented logic.

---
 rtl/deser_pkg.sv | 17 +
 rtl/deser_bit_counter.sv | 35 +++
 rtl/serial_word_deserializer.sv | 113 +++++++++++
 tb/tb_serial_word_deserializer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial word deserializer.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;

  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Bit counter for one frame; tc_o flags that the next accepted bit ends the frame.
// With DESER_PARITY_CHECK_EN the frame is N data bits plus one parity bit.
module deser_bit_counter
  import deser_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic load_one_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW = cnt_w(N);
`ifdef DESER_PARITY_CHECK_EN
  localparam int TC = N + 1;
`else
  localparam int TC = N;
`endif

  logic [CW-1:0] cnt_q;

  // A restart (load_one) wins over clear so a sof on the final bit slot starts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt_q <= '0;
    else if (load_one_i) cnt_q <= CW'(1);
    else if (clear_i)    cnt_q <= '0;
    else if (inc_i)      cnt_q <= cnt_q + CW'(1);
  end

  assign tc_o = (cnt_q == CW'(TC - 1));

endmodule

// File: rtl/serial_word_deserializer.sv
// Framed serial-to-parallel deserializer with valid/ready output, frame restart
// and overrun flags. Optional trailing even parity via DESER_PARITY_CHECK_EN.
module serial_word_deserializer
  import deser_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_in,
  input  logic         bit_valid,
  input  logic         sof,
  input  logic         msb_first,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_err,
  output logic         overrun,
  output logic         parity_err
);

  state_e       state_q;
  logic [N-1:0] sreg_q, data_q;
  logic         valid_q, ferr_q, ovr_q, msbf_q;
  logic [N-1:0] shift_d, first_d, word_d;
  logic         hs, accept_sof, bit_cnt, tc;

  assign hs         = valid_q && out_ready;
  assign accept_sof = bit_valid && sof && (state_q != DONE || hs);
  assign bit_cnt    = (state_q == SHIFT) && bit_valid && !sof;

  always_comb begin
    shift_d = (msbf_q == MSB_FIRST) ? {sreg_q[N-2:0], bit_in} : {bit_in, sreg_q[N-1:1]};
    first_d = (msb_first == MSB_FIRST) ? {{(N-1){1'b0}}, bit_in} : {bit_in, {(N-1){1'b0}}};
  end

`ifdef DESER_PARITY_CHECK_EN
  // The last bit is parity: the word is already complete in sreg_q.
  assign word_d = sreg_q;
  logic perr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 perr_q <= 1'b0;
    else if (bit_cnt && tc)                  perr_q <= ^sreg_q ^ bit_in;
    else if (state_q == DONE && hs)          perr_q <= 1'b0;
  end
  assign parity_err = perr_q;
`else
  assign word_d     = shift_d;
  assign parity_err = 1'b0;
`endif

  deser_bit_counter #(.N(N)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (bit_cnt && tc),
    .load_one_i(accept_sof),
    .inc_i     (bit_cnt),
    .tc_o      (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      msbf_q  <= LSB_FIRST;
    end else begin
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: if (bit_valid && sof) begin
          sreg_q  <= first_d;
          msbf_q  <= msb_first;
          state_q <= SHIFT;
        end
        SHIFT: if (bit_valid) begin
          if (sof) begin
            sreg_q <= first_d;
            msbf_q <= msb_first;
            ferr_q <= 1'b1;
          end else if (tc) begin
            data_q  <= word_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            sreg_q <= shift_d;
          end
        end
        DONE: if (hs) begin
          valid_q <= 1'b0;
          if (bit_valid && sof) begin
            sreg_q  <= first_d;
            msbf_q  <= msb_first;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end else if (bit_valid) begin
          ovr_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed self-checking bench for serial_word_deserializer at N=4.
module tb_serial_word_deserializer;

  logic       clk, rst, bit_in, bit_valid, sof, msb_first, out_ready;
  logic [3:0] data_out;
  logic       out_valid, frame_err, overrun, parity_err;
  int         total, bad;

  serial_word_deserializer #(.N(4)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .msb_first(msb_first), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s, input logic m);
    bit_in = b; sof = s; msb_first = m; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0; sof = 1'b0;
  endtask

  // b[3] is sent first; p is the trailing parity bit when parity framing is built in.
  task automatic send_frame(input logic [3:0] b, input logic m, input logic p);
    for (int i = 3; i >= 0; i--) send_bit(b[i], i == 3, m);
`ifdef DESER_PARITY_CHECK_EN
    send_bit(p, 1'b0, m);
`else
    if (p) begin end
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
    msb_first = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_data", data_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_perr", parity_err, 0);
    rst = 1'b0;
    tick();

    // LSB-first 0,1,0,1 -> 1010, held until ready
    send_frame(4'b0101, 1'b0, 1'b0);
    chk("lsb_valid", out_valid, 1);
    chk("lsb_data", data_out, 4'b1010);
    tick(); tick();
    chk("lsb_hold_valid", out_valid, 1);
    chk("lsb_hold_data", data_out, 4'b1010);
    out_ready = 1'b1;
    tick();
    chk("lsb_accept", out_valid, 0);
    out_ready = 1'b0;

    // MSB-first 1,0,1,1 -> 1011
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    chk("msb_not_yet", out_valid, 0);
    send_bit(1'b1, 1'b0, 1'b1);
`ifdef DESER_PARITY_CHECK_EN
    send_bit(1'b1, 1'b0, 1'b1);
`endif
    chk("msb_valid", out_valid, 1);
    chk("msb_data", data_out, 4'b1011);
`ifdef DESER_PARITY_CHECK_EN
    chk("par_good", parity_err, 0);
`endif
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("msb_accept", out_valid, 0);

    // restart mid-frame: sof+1,1 then sof+0,0,1,1 -> 0011
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    chk("restart_noerr", frame_err, 0);
    send_bit(1'b0, 1'b1, 1'b1);
    chk("restart_ferr", frame_err, 1);
    send_bit(1'b0, 1'b0, 1'b1);
    chk("restart_ferr_pulse", frame_err, 0);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
`ifdef DESER_PARITY_CHECK_EN
    send_bit(1'b1, 1'b0, 1'b1);
    chk("par_bad", parity_err, 1);
`endif
    chk("restart_valid", out_valid, 1);
    chk("restart_data", data_out, 4'b0011);

    // overrun while word is held
    chk("ovr_before", overrun, 0);
    send_bit(1'b1, 1'b0, 1'b1);
    chk("ovr_set", overrun, 1);
    chk("ovr_data", data_out, 4'b0011);
    chk("ovr_valid", out_valid, 1);
    tick();
    chk("ovr_sticky", overrun, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("ovr_sticky2", overrun, 1);

    // clear the sticky flag before back-to-back
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // back-to-back: second sof lands in the handshake cycle
    out_ready = 1'b1;
    send_frame(4'b1100, 1'b1, 1'b0);
    chk("b2b_v1", out_valid, 1);
    chk("b2b_d1", data_out, 4'b1100);
    send_frame(4'b0110, 1'b1, 1'b0);
    chk("b2b_v2", out_valid, 1);
    chk("b2b_d2", data_out, 4'b0110);
    chk("b2b_ovr", overrun, 0);
    chk("b2b_ferr", frame_err, 0);
    tick();
    chk("b2b_drop", out_valid, 0);
    out_ready = 1'b0;

    // async reset between edges after 2 bits
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_valid", out_valid, 0);
    rst = 1'b0;
    tick();
    send_frame(4'b0101, 1'b1, 1'b0);
    chk("arst_next_valid", out_valid, 1);
    chk("arst_next_data", data_out, 4'b0101);
    chk("arst_next_perr", parity_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
